// File: rtl/eic_pkg.sv
// Shared definitions for the external interrupt controller and its bus-side
// vector fetcher: controller register offsets, fetcher FSM states and a
// priority-encode helper.
package eic_pkg;

    // Controller register offsets, relative to the controller base address.
    localparam logic [31:0] EIC_MASK_OFF   = 32'h0;
    localparam logic [31:0] EIC_CIP_OFF    = 32'h4;
    localparam logic [31:0] EIC_IRQNUM_OFF = 32'h8;
    localparam logic [31:0] EIC_IRQBIT_OFF = 32'hC;

    typedef enum logic [2:0] {
        IDLE,
        RD_BIT,
        RD_VEC,
        PRESENT,
        SERVICE,
        WR_CIP
    } ivf_state_t;

    // Index of the lowest set bit (LSB wins); returns 0 for an all-zero input,
    // which callers screen out beforehand.
    function automatic logic [3:0] lowest_set_index(input logic [15:0] v);
        lowest_set_index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set_index = 4'(i);
        end
    endfunction

endpackage

// File: rtl/wb_xfer_engine.sv
// Single-beat Wishbone transfer engine. The sequencing FSM holds the request
// fields in registers; this block drives them onto the bus, reports completion
// in the same cycle as ack/err, and owns the per-transfer timeout counter.
module wb_xfer_engine #(
    parameter int TimeoutCycles = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    // request side (registered by the sequencer)
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    // completion side
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] rdata_o,
    // Wishbone initiator
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_wdata_o,
    input  logic [31:0] wb_rdata_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    // The counter value at which one more wait cycle reaches TimeoutCycles.
    localparam logic [7:0] LastWait = 8'(TimeoutCycles - 1);

    logic [7:0] wait_q;
    logic [7:0] wait_d;
    logic       timeout;

    // cyc and stb are always asserted together for a single-beat transfer.
    assign wb_cyc_o   = req_i;
    assign wb_stb_o   = req_i;
    assign wb_we_o    = we_i;
    assign wb_sel_o   = sel_i;
    assign wb_addr_o  = addr_i;
    assign wb_wdata_o = wdata_i;
    assign rdata_o    = wb_rdata_i;

    // Completion decode and next wait count.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; assigning them up front keeps the block latch-free.
        timeout = 1'b0;
        done_o  = 1'b0;
        error_o = 1'b0;
        wait_d  = wait_q;
        if (req_i) begin
            timeout = !wb_ack_i && !wb_err_i && (wait_q == LastWait);
            done_o  = wb_ack_i || wb_err_i || timeout;
            error_o = wb_err_i || timeout;
            wait_d  = done_o ? 8'd0 : wait_q + 8'd1;
        end else begin
            wait_d = 8'd0;
        end
    end

    // Wait counter: cleared between transfers, counts stalled cycles.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wait_q <= 8'd0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values regardless of statement order.
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/irq_vector_fetcher.sv
// Bus-side interrupt vector fetcher. On ext_irq it reads the controller's
// active-IRQ-bit register, fetches the handler address from the vector table,
// presents it to the core, and after end-of-interrupt writes the
// clear-pending register. The Wishbone initiator port is carried as
// individual bus_* signals.
module irq_vector_fetcher #(
    parameter logic [31:0] EicBase       = 32'h0000_4010,
    parameter logic [31:0] VectorBase    = 32'h0000_0100,
    parameter logic [31:0] DefaultVector = 32'h0000_0000,
    parameter int          TimeoutCycles = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        ext_irq_in,
    // Wishbone initiator
    output logic        bus_cyc_out,
    output logic        bus_stb_out,
    output logic        bus_we_out,
    output logic [3:0]  bus_sel_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    input  logic [31:0] bus_rdata_in,
    input  logic        bus_ack_in,
    input  logic        bus_err_in,
    // core handshake
    output logic        vec_valid_out,
    input  logic        vec_ready_in,
    output logic [31:0] vec_addr_out,
    output logic [3:0]  irq_num_out,
    input  logic        eoi_in,
    // status
    output logic        busy_out,
    output logic        spurious_out,
    output logic        bus_err_out
);

    import eic_pkg::*;

    ivf_state_t  state_q;
    logic        req_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] bit_q;
    logic [3:0]  num_q;
    logic [31:0] vec_q;
    logic        valid_q;
    logic        busy_q;
    logic        spur_q;
    logic        err_q;

    logic        xfer_done;
    logic        xfer_error;
    logic [31:0] xfer_rdata;
    logic [15:0] rd_bits;
    logic [3:0]  rd_num;
    logic [15:0] rd_bit;

    wb_xfer_engine #(
        .TimeoutCycles(TimeoutCycles)
    ) u_xfer (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .req_i     (req_q),
        .addr_i    (addr_q),
        .we_i      (we_q),
        .sel_i     (sel_q),
        .wdata_i   (wdata_q),
        .done_o    (xfer_done),
        .error_o   (xfer_error),
        .rdata_o   (xfer_rdata),
        .wb_cyc_o  (bus_cyc_out),
        .wb_stb_o  (bus_stb_out),
        .wb_we_o   (bus_we_out),
        .wb_sel_o  (bus_sel_out),
        .wb_addr_o (bus_addr_out),
        .wb_wdata_o(bus_wdata_out),
        .wb_rdata_i(bus_rdata_in),
        .wb_ack_i  (bus_ack_in),
        .wb_err_i  (bus_err_in)
    );

    // Only the low 16 IRQ-bit lanes are meaningful; the lowest one is serviced.
    assign rd_bits = xfer_rdata[15:0];
    assign rd_num  = lowest_set_index(rd_bits);
    assign rd_bit  = 16'd1 << rd_num;

    assign vec_valid_out = valid_q;
    assign vec_addr_out  = vec_q;
    assign irq_num_out   = num_q;
    assign busy_out      = busy_q;
    assign spurious_out  = spur_q;
    assign bus_err_out   = err_q;

    // Sequencer: drives bus requests and all handshake/status outputs from
    // registers. Back-to-back RD_BIT -> RD_VEC keeps the request asserted and
    // swaps the address on the ack edge.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            bit_q   <= 16'h0;
            num_q   <= 4'h0;
            vec_q   <= 32'h0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            spur_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            spur_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ext_irq_in) begin
                        state_q <= RD_BIT;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        sel_q   <= 4'hF;
                        addr_q  <= EicBase + EIC_IRQBIT_OFF;
                    end
                end
                RD_BIT: begin
                    if (xfer_done) begin
                        if (xfer_error) begin
                            err_q   <= 1'b1;
                            req_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (rd_bits == 16'h0) begin
                            spur_q  <= 1'b1;
                            req_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            bit_q   <= rd_bit;
                            num_q   <= rd_num;
                            addr_q  <= VectorBase + {26'd0, rd_num, 2'b00};
                            state_q <= RD_VEC;
                        end
                    end
                end
                RD_VEC: begin
                    if (xfer_done) begin
                        req_q   <= 1'b0;
                        vec_q   <= xfer_error ? DefaultVector : xfer_rdata;
                        if (xfer_error) err_q <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (vec_ready_in) begin
                        valid_q <= 1'b0;
                        state_q <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi_in) begin
                        state_q <= WR_CIP;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        sel_q   <= 4'h3;
                        addr_q  <= EicBase + EIC_CIP_OFF;
                        wdata_q <= {16'h0, bit_q};
                    end
                end
                WR_CIP: begin
                    if (xfer_done) begin
                        err_q   <= xfer_error;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_vector_fetcher.sv
// Self-checking bench for irq_vector_fetcher: a Wishbone slave model with
// programmable wait states and errors, a table of directed vectors, random
// transactions checked against a behavioural model, and hand-written corner
// sequences (timeout, backpressure, reset mid-transfer).
module tb_irq_vector_fetcher;

    localparam logic [31:0] EIC  = 32'h0000_4010;
    localparam logic [31:0] VB   = 32'h0000_0100;
    localparam logic [31:0] DEFV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_irq = 1'b0;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic [31:0] s_rdata;
    logic        s_ack, s_err;
    logic        vec_valid;
    logic        vec_ready = 1'b0;
    logic [31:0] vec_addr;
    logic [3:0]  irq_num;
    logic        eoi = 1'b0;
    logic        busy, spurious, bus_err;

    always #5 clk = ~clk;

    irq_vector_fetcher dut (
        .clk_in       (clk),
        .reset_in     (rst_n),
        .ext_irq_in   (ext_irq),
        .bus_cyc_out  (cyc),
        .bus_stb_out  (stb),
        .bus_we_out   (we),
        .bus_sel_out  (sel),
        .bus_addr_out (addr),
        .bus_wdata_out(wdata),
        .bus_rdata_in (s_rdata),
        .bus_ack_in   (s_ack),
        .bus_err_in   (s_err),
        .vec_valid_out(vec_valid),
        .vec_ready_in (vec_ready),
        .vec_addr_out (vec_addr),
        .irq_num_out  (irq_num),
        .eoi_in       (eoi),
        .busy_out     (busy),
        .spurious_out (spurious),
        .bus_err_out  (bus_err)
    );

    // ---------------- slave model ----------------
    logic [31:0] bit_word = 32'h0;
    logic [31:0] mem [16];
    int          bw = 0, vw = 0, cw = 0;
    bit          verr_en = 1'b0;
    int          wcnt;
    int          vec_reads, writes;
    logic [31:0] last_raddr, last_waddr, last_wdata;
    logic [3:0]  last_wsel;

    always_comb begin
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rdata = 32'h0;
        if (cyc && stb) begin
            if (addr == EIC + 32'hC) begin
                s_rdata = bit_word;
                s_ack   = (wcnt == bw);
            end else if (addr == EIC + 32'h4) begin
                s_ack = (wcnt == cw);
            end else begin
                s_rdata = mem[addr[5:2]];
                if (wcnt == vw) begin
                    if (verr_en) s_err = 1'b1;
                    else         s_ack = 1'b1;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else begin
            if (!(cyc && stb) || s_ack || s_err) wcnt <= 0;
            else                                 wcnt <= wcnt + 1;
            if (cyc && stb && (s_ack || s_err) && addr != EIC + 32'hC && addr != EIC + 32'h4) begin
                vec_reads  <= vec_reads + 1;
                last_raddr <= addr;
            end
            if (cyc && stb && s_ack && we) begin
                writes     <= writes + 1;
                last_waddr <= addr;
                last_wdata <= wdata;
                last_wsel  <= sel;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;
    bit model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: which IRQ line is serviced for a given bit register.
    function automatic int model_num(input logic [31:0] word);
        logic [15:0] lo;
        int k;
        lo = word[15:0];
        if (lo == 16'h0) return -1;
        k = 0;
        while (lo[k] == 1'b0) k++;
        return k;
    endfunction

    // One complete interrupt service, checked against the given expectations.
    task automatic do_irq(input logic [31:0] bitword, input logic [31:0] vword,
                          input int vidx, input bit verr,
                          input int b_w, input int v_w, input int c_w,
                          input bit exp_spur, input logic [3:0] exp_num,
                          input logic [31:0] exp_vec, input logic [31:0] exp_raddr,
                          input logic [31:0] exp_wdata, input string tag);
        int n;
        int vr0, wr0;
        bit zero;
        zero = (b_w == 0 && v_w == 0 && c_w == 0);
        bit_word = bitword;
        mem[vidx] = vword;
        verr_en = verr;
        bw = b_w; vw = v_w; cw = c_w;
        vr0 = vec_reads;
        wr0 = writes;
        @(negedge clk); ext_irq = 1'b1;
        @(negedge clk); ext_irq = 1'b0;
        check({tag, " busy after irq"}, 32'(busy), 32'd1);
        if (exp_spur) begin
            n = 0;
            while (!spurious && n < b_w + 4) begin @(negedge clk); n++; end
            check({tag, " spurious pulse"}, 32'(spurious), 32'd1);
            if (zero) check({tag, " spurious latency"}, n, 1);
            @(negedge clk);
            check({tag, " spurious width"}, 32'(spurious), 32'd0);
            check({tag, " idle after spurious"}, 32'(busy), 32'd0);
            check({tag, " no vector read"}, vec_reads - vr0, 0);
            check({tag, " no clear write"}, writes - wr0, 0);
            check({tag, " bus_err kept"}, 32'(bus_err), 32'(model_err));
        end else begin
            n = 0;
            while (!vec_valid && n < b_w + v_w + 8) begin @(negedge clk); n++; end
            check({tag, " vec_valid"}, 32'(vec_valid), 32'd1);
            if (zero) check({tag, " valid latency"}, n, 2);
            check({tag, " irq_num"}, 32'(irq_num), 32'(exp_num));
            check({tag, " vec_addr"}, vec_addr, exp_vec);
            check({tag, " table addr"}, last_raddr, exp_raddr);
            if (verr) model_err = 1'b1;
            check({tag, " bus_err present"}, 32'(bus_err), 32'(model_err));
            vec_ready = 1'b1;
            @(negedge clk); vec_ready = 1'b0;
            check({tag, " valid dropped"}, 32'(vec_valid), 32'd0);
            eoi = 1'b1;
            @(negedge clk); eoi = 1'b0;
            if (zero) begin
                check({tag, " cip cyc"}, 32'(cyc && stb && we), 32'd1);
                check({tag, " cip addr"}, addr, EIC + 32'h4);
            end
            n = 0;
            while (busy && n < c_w + 4) begin @(negedge clk); n++; end
            check({tag, " idle after cip"}, 32'(busy), 32'd0);
            if (zero) check({tag, " cip latency"}, n, 1);
            check({tag, " one write"}, writes - wr0, 1);
            check({tag, " cip wdata"}, last_wdata, exp_wdata);
            check({tag, " cip waddr"}, last_waddr, 32'h0000_4014);
            check({tag, " cip sel"}, 32'(last_wsel), 32'h3);
            model_err = 1'b0;
            check({tag, " bus_err cleared"}, 32'(bus_err), 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] bitword;
        logic [31:0] vword;
        int          vidx;
        bit          verr;
        bit          exp_spur;
        logic [3:0]  exp_num;
        logic [31:0] exp_vec;
        logic [31:0] exp_raddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, unstable, cyc_seen;
        logic [31:0] v0;
        logic [3:0]  n0;

        tbl[0] = '{32'h0000_0020, 32'h0000_2000, 5,  1'b0, 1'b0, 4'd5,  32'h0000_2000, 32'h0000_0114, 32'h0000_0020};
        tbl[1] = '{32'hFFFF_0000, 32'h1111_1111, 0,  1'b0, 1'b1, 4'd0,  32'h0,         32'h0,         32'h0};
        tbl[2] = '{32'h0000_8402, 32'h0000_3344, 1,  1'b0, 1'b0, 4'd1,  32'h0000_3344, 32'h0000_0104, 32'h0000_0002};
        tbl[3] = '{32'h0000_8000, 32'hCAFE_F00D, 15, 1'b0, 1'b0, 4'd15, 32'hCAFE_F00D, 32'h0000_013C, 32'h0000_8000};
        tbl[4] = '{32'h0000_0001, 32'h5555_AAAA, 0,  1'b1, 1'b0, 4'd0,  DEFV,          32'h0000_0100, 32'h0000_0001};
        tbl[5] = '{32'hABCD_0C00, 32'h0000_7777, 10, 1'b0, 1'b0, 4'd10, 32'h0000_7777, 32'h0000_0128, 32'h0000_0400};

        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        vec_reads = 0; writes = 0;
        last_raddr = 0; last_waddr = 0; last_wdata = 0; last_wsel = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset cyc", 32'(cyc), 32'd0);
        check("reset stb", 32'(stb), 32'd0);
        check("reset addr", addr, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(vec_valid), 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 6; i++) begin
            do_irq(tbl[i].bitword, tbl[i].vword, tbl[i].vidx, tbl[i].verr, 0, 0, 0,
                   tbl[i].exp_spur, tbl[i].exp_num, tbl[i].exp_vec, tbl[i].exp_raddr,
                   tbl[i].exp_wdata, $sformatf("tbl%0d", i));
        end

        // timeout on RD_BIT
        bw = 1000; bit_word = 32'h1; verr_en = 1'b0;
        @(negedge clk); ext_irq = 1'b1;
        @(negedge clk); ext_irq = 1'b0;
        n = 0;
        while (cyc && n < 400) begin n++; @(negedge clk); end
        check("timeout cyc cycles", n, 255);
        check("timeout idle", 32'(busy), 32'd0);
        check("timeout bus_err", 32'(bus_err), 32'd1);
        check("timeout no spurious", 32'(spurious), 32'd0);
        model_err = 1'b1;
        bw = 0;

        // random transactions against the model (also clears the sticky error)
        for (int i = 0; i < 24; i++) begin
            logic [31:0] bwd, vwd;
            bit ve;
            int k;
            bwd = $urandom;
            if ($urandom_range(0, 7) == 0) bwd[15:0] = 16'h0;
            vwd = $urandom;
            ve  = ($urandom_range(0, 3) == 0);
            k   = model_num(bwd);
            do_irq(bwd, vwd, (k < 0) ? 0 : k, ve,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   k < 0, (k < 0) ? 4'd0 : 4'(k), ve ? DEFV : vwd,
                   VB + 32'(4 * ((k < 0) ? 0 : k)), 32'd1 << ((k < 0) ? 0 : k),
                   $sformatf("rnd%0d", i));
        end

        // backpressure: ready withheld, eoi during PRESENT ignored
        bw = 0; vw = 0; cw = 0; verr_en = 1'b0;
        bit_word = 32'h0000_0040; mem[6] = 32'h0000_6000;
        @(negedge clk); ext_irq = 1'b1;
        @(negedge clk); ext_irq = 1'b0;
        n = 0;
        while (!vec_valid && n < 10) begin @(negedge clk); n++; end
        v0 = vec_addr; n0 = irq_num;
        check("bp vec_addr", v0, 32'h0000_6000);
        check("bp irq_num", 32'(n0), 32'd6);
        unstable = 0; cyc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            eoi = (i == 3);
            @(negedge clk);
            eoi = 1'b0;
            if (vec_addr !== v0 || irq_num !== n0 || vec_valid !== 1'b1) unstable++;
            if (cyc) cyc_seen++;
        end
        check("bp unstable cycles", unstable, 0);
        check("bp eoi ignored in PRESENT", cyc_seen, 0);
        vec_ready = 1'b1;
        @(negedge clk); vec_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp service waits", 32'(busy && !cyc), 32'd1);
        eoi = 1'b1;
        @(negedge clk); eoi = 1'b0;
        n = 0;
        while (busy && n < 5) begin @(negedge clk); n++; end
        check("bp cip wdata", last_wdata, 32'h0000_0040);

        // reset during a wait-stated RD_VEC
        n = writes;
        vw = 20; bit_word = 32'h0000_0004;
        @(negedge clk); ext_irq = 1'b1;
        @(negedge clk); ext_irq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst in RD_VEC addr", addr, 32'h0000_0108);
        check("rst in RD_VEC cyc", 32'(cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst async cyc/stb", {30'd0, cyc, stb}, 32'd0);
        check("rst async outputs", {22'd0, busy, vec_valid, spurious, bus_err, irq_num, we, sel != 4'h0},
              32'd0);
        check("rst async addr/vec", addr | wdata | vec_addr, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst no clear write", writes - n, 0);
        check("rst stays idle", 32'(busy || cyc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
